// File: rtl/regfile_pkg.sv
// Shared defaults and address-width helper for the register file family.
package regfile_pkg;

  localparam int DEFAULT_NBITS = 32;
  localparam int DEFAULT_NREGS = 32;

  // At least one address bit, even for the smallest legal register count.
  function automatic int addrWidth(input int nregs);
    return (nregs > 2) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/register_rst_en.sv
// One storage word: synchronous active-high clear, load when enabled.
module register_rst_en #(
  parameter int p_nbits = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [p_nbits-1:0] d_i,
  output logic [p_nbits-1:0] q_o
);

  logic [p_nbits-1:0] data_q;
  logic [p_nbits-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/regfile_flat_2r1w.sv
// Flat register file, two combinational read ports and one write port.
// Define REGFILE_FLAT_2R1W_BYPASS_EN to forward same-cycle write data to readers.
module regfile_flat_2r1w
  import regfile_pkg::*;
#(
  parameter int p_nbits    = DEFAULT_NBITS,
  parameter int p_nregs    = DEFAULT_NREGS,
  parameter bit p_zero_reg = 1'b0,
  localparam int AW        = addrWidth(p_nregs)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wen,
  input  logic [AW-1:0]      waddr,
  input  logic [p_nbits-1:0] wdata,
  input  logic [AW-1:0]      raddr0,
  output logic [p_nbits-1:0] rdata0,
  input  logic [AW-1:0]      raddr1,
  output logic [p_nbits-1:0] rdata1
);

  logic [p_nbits-1:0] regData_q [p_nregs];
  logic [p_nregs-1:0] wrSel;
  logic               wrValid;

  // A write lands only when in range, outside reset, and not aimed at a hardwired zero.
  assign wrValid = wen && !rst && (int'(waddr) < p_nregs)
                   && !(p_zero_reg && (waddr == '0));

  for (genvar i = 0; i < p_nregs; i++) begin : g_reg
    assign wrSel[i] = wrValid && (int'(waddr) == i);

    register_rst_en #(
      .p_nbits(p_nbits)
    ) u_reg (
      .clk_i(clk),
      .rst_i(rst),
      .en_i (wrSel[i]),
      .d_i  (wdata),
      .q_o  (regData_q[i])
    );
  end

  function automatic logic [p_nbits-1:0] readPort(input logic [AW-1:0] addr);
    logic [p_nbits-1:0] value;
    value = '0;
    if ((int'(addr) < p_nregs) && !(p_zero_reg && (addr == '0))) begin
      value = regData_q[addr];
    end
`ifdef REGFILE_FLAT_2R1W_BYPASS_EN
    if (wrValid && (waddr == addr)) begin
      value = wdata;
    end
`endif
    return value;
  endfunction

  always_comb begin
    rdata0 = readPort(raddr0);
  end

  always_comb begin
    rdata1 = readPort(raddr1);
  end

endmodule

// File: tb/tb_regfile_flat_2r1w.sv
// Randomized and directed bench for regfile_flat_2r1w against an array model.
module tb_regfile_flat_2r1w;

  localparam int NBITS = 8;
  localparam int NREGS = 6;
  localparam int AW    = 3;
`ifdef REGFILE_FLAT_2R1W_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             wen;
  logic [AW-1:0]    waddr;
  logic [NBITS-1:0] wdata;
  logic [AW-1:0]    raddr0;
  logic [AW-1:0]    raddr1;
  logic [NBITS-1:0] rdata0, rdata1;
  logic [NBITS-1:0] zRdata0, zRdata1;

  logic [NBITS-1:0] memPlain [NREGS];
  logic [NBITS-1:0] memZero  [NREGS];
  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  regfile_flat_2r1w #(.p_nbits(NBITS), .p_nregs(NREGS), .p_zero_reg(1'b0)) dut (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr0(raddr0), .rdata0(rdata0), .raddr1(raddr1), .rdata1(rdata1)
  );

  regfile_flat_2r1w #(.p_nbits(NBITS), .p_nregs(NREGS), .p_zero_reg(1'b1)) dutZero (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr0(raddr0), .rdata0(zRdata0), .raddr1(raddr1), .rdata1(zRdata1)
  );

  task automatic checkOutput(input string tag, input logic [NBITS-1:0] obs,
                             input logic [NBITS-1:0] exp);
    checkCount++;
    if (obs !== exp) begin
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end else begin
      passCount++;
    end
  endtask

  // Expected read value from the stated rules, given the model contents.
  function automatic logic [NBITS-1:0] expRead(input bit zero, input int addr);
    logic [NBITS-1:0] stored;
    if (addr >= NREGS) return '0;
    if (zero && addr == 0) return '0;
    if (BYPASS && wen && !rst && int'(waddr) == addr && !(zero && waddr == 0)) return wdata;
    stored = zero ? memZero[addr] : memPlain[addr];
    return stored;
  endfunction

  task automatic updateModel();
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        memPlain[i] = '0;
        memZero[i]  = '0;
      end
    end else if (wen && int'(waddr) < NREGS) begin
      memPlain[waddr] = wdata;
      if (waddr != 0) memZero[waddr] = wdata;
    end
  endtask

  // Drive one cycle, check all four read ports mid-cycle, then clock it in.
  task automatic applyStimulus(input logic r, input logic we, input logic [AW-1:0] wa,
                               input logic [NBITS-1:0] wd, input logic [AW-1:0] ra0,
                               input logic [AW-1:0] ra1);
    rst = r; wen = we; waddr = wa; wdata = wd; raddr0 = ra0; raddr1 = ra1;
    #3;
    checkOutput("plain_rd0", rdata0,  expRead(1'b0, int'(ra0)));
    checkOutput("plain_rd1", rdata1,  expRead(1'b0, int'(ra1)));
    checkOutput("zero_rd0",  zRdata0, expRead(1'b1, int'(ra0)));
    checkOutput("zero_rd1",  zRdata1, expRead(1'b1, int'(ra1)));
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic probe(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    rst = 1'b0; wen = 1'b0; raddr0 = ra0; raddr1 = ra1;
    #2;
  endtask

  initial begin
    rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0; raddr0 = '0; raddr1 = '0;
    @(posedge clk);
    updateModel();
    #1;

    // Reset state on every in-range address.
    for (int a = 0; a < NREGS; a++) begin
      probe(AW'(a), AW'(a));
      checkOutput("reset_val", rdata0, 8'h00);
    end

    // Write then read back on both ports.
    applyStimulus(1'b0, 1'b1, 3'd3, 8'h5A, 3'd0, 3'd1);
    probe(3'd3, 3'd3);
    checkOutput("wr_rd_p0", rdata0, 8'h5A);
    checkOutput("wr_rd_p1", rdata1, 8'h5A);

    // Collision: r2 holds 0x11, then 0xC3 is written while being read.
    applyStimulus(1'b0, 1'b1, 3'd2, 8'h11, 3'd3, 3'd2);
    rst = 1'b0; wen = 1'b1; waddr = 3'd2; wdata = 8'hC3; raddr0 = 3'd2; raddr1 = 3'd3;
    #2;
    checkOutput("collision", rdata0, BYPASS ? 8'hC3 : 8'h11);
    applyStimulus(1'b0, 1'b1, 3'd2, 8'hC3, 3'd2, 3'd3);
    probe(3'd2, 3'd2);
    checkOutput("post_collision", rdata0, 8'hC3);

    // Reset wins over a simultaneous write, and no bypass during reset.
    applyStimulus(1'b1, 1'b1, 3'd1, 8'hFF, 3'd1, 3'd3);
    probe(3'd1, 3'd1);
    checkOutput("rst_prio", rdata0, 8'h00);
    for (int a = 0; a < NREGS; a++) begin
      probe(AW'(a), AW'(a));
      checkOutput("rst_all", rdata1, 8'h00);
    end

    // Out-of-range write is dropped, out-of-range read is zero.
    applyStimulus(1'b0, 1'b1, 3'd4, 8'h3C, 3'd0, 3'd0);
    applyStimulus(1'b0, 1'b1, 3'd7, 8'h77, 3'd4, 3'd7);
    probe(3'd4, 3'd7);
    checkOutput("oor_rd", rdata1, 8'h00);
    checkOutput("oor_keep", rdata0, 8'h3C);
    for (int a = 0; a < 8; a++) applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, AW'(a), AW'(7 - a));

    // Hardwired zero register, including the write cycle itself.
    rst = 1'b0; wen = 1'b1; waddr = 3'd0; wdata = 8'hAA; raddr0 = 3'd0; raddr1 = 3'd0;
    #2;
    checkOutput("zero_same_cyc", zRdata0, 8'h00);
    checkOutput("plain_r0_same", rdata0, BYPASS ? 8'hAA : 8'h00);
    applyStimulus(1'b0, 1'b1, 3'd0, 8'hAA, 3'd0, 3'd0);
    probe(3'd0, 3'd0);
    checkOutput("zero_after", zRdata0, 8'h00);
    checkOutput("plain_r0_after", rdata0, 8'hAA);

    // Random traffic, including out-of-range addresses and occasional reset.
    for (int c = 0; c < 200; c++) begin
      applyStimulus(($urandom_range(0, 9) == 0), 1'($urandom), AW'($urandom),
                    NBITS'($urandom), AW'($urandom), AW'($urandom));
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
